aes_decrypt_scheduler: RTL and testbench

Time-multiplexes one unfolded, non-pipelined AES-128 decrypt core (`Unfolded_not_pipeline_decrypt`) among `NUM_REQ` independent requesters. It runs a round-robin valid/ready request channel, holds key/ciphertext stable at the core for a fixed settle window, and captures the plaintext. It returns the plaintext on a single tagged response channel with backpressure. It sits between the system's decrypt clients and the decrypt core, so only one operation occupies the core at a time.

---
 rtl/aes_dec_pkg.sv | 83 ++++++++
 rtl/Unfolded_not_pipeline_decrypt.sv | 20 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/aes_decrypt_scheduler.sv | 90 +++++++++
 tb/tb_aes_decrypt_scheduler.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared AES widths, scheduler state type and GF(2^8) helpers
// used by the combinational AES-128 inverse cipher.
package aes_dec_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;

    typedef enum logic [1:0] {IDLE, RUN, RESP} dec_sched_state_t;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] a);
        return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [127:0] aes_dec128(input logic [127:0] ct, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] st;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sub_byte(tmp[23:16]) ^ rc, sub_byte(tmp[15:8]), sub_byte(tmp[7:0]), sub_byte(tmp[31:24])};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        st = ct ^ {w[40], w[41], w[42], w[43]};
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = inv_sub_byte(a[(i%4) + 4*(((i/4) - (i%4) + 4) % 4)]);
            st ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            if (r != 0) begin
                for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
                for (int c = 0; c < 4; c++) begin
                    b[4*c]   = gmul(a[4*c], 8'h0e) ^ gmul(a[4*c+1], 8'h0b) ^ gmul(a[4*c+2], 8'h0d) ^ gmul(a[4*c+3], 8'h09);
                    b[4*c+1] = gmul(a[4*c], 8'h09) ^ gmul(a[4*c+1], 8'h0e) ^ gmul(a[4*c+2], 8'h0b) ^ gmul(a[4*c+3], 8'h0d);
                    b[4*c+2] = gmul(a[4*c], 8'h0d) ^ gmul(a[4*c+1], 8'h09) ^ gmul(a[4*c+2], 8'h0e) ^ gmul(a[4*c+3], 8'h0b);
                    b[4*c+3] = gmul(a[4*c], 8'h0b) ^ gmul(a[4*c+1], 8'h0d) ^ gmul(a[4*c+2], 8'h09) ^ gmul(a[4*c+3], 8'h0e);
                end
                for (int i = 0; i < 16; i++) st[127-8*i -: 8] = b[i];
            end
        end
        return st;
    endfunction
endpackage

// File: rtl/Unfolded_not_pipeline_decrypt.sv
// Unfolded_not_pipeline_decrypt: all ten AES-128 inverse rounds unrolled in
// one combinational cloud, with a single output register.
module Unfolded_not_pipeline_decrypt
    import aes_dec_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [AES_KEY_W-1:0]   key_i,
    input  logic [AES_BLOCK_W-1:0] Cipher_i,
    output logic [AES_BLOCK_W-1:0] text_o
);
    logic [AES_BLOCK_W-1:0] w_text;

    always_comb w_text = aes_dec128(Cipher_i, key_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) text_o <= '0;
        else         text_o <= w_text;
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter; grants the first request
// at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    int w_idx;

    // scan offsets from far to near so the closest request wins last
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_idx   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = (int'(ptr) + i) % N;
            if (req[w_idx]) begin
                gnt        = '0;
                gnt[w_idx] = 1'b1;
                gnt_idx    = IW'(w_idx);
            end
        end
    end
endmodule

// File: rtl/aes_decrypt_scheduler.sv
// aes_decrypt_scheduler: round-robin shares one AES-128 decrypt core among
// NUM_REQ requesters and returns tagged plaintexts on one response channel.
module aes_decrypt_scheduler
    import aes_dec_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key_i,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_cipher_i,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [ID_W-1:0]                resp_id_o,
    output logic [AES_BLOCK_W-1:0]         resp_text_o,
    output logic                           busy_o
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    dec_sched_state_t       r_state, w_next;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [ID_W-1:0]        w_gnt_idx, r_rr_ptr, r_id;
    logic [CNT_W-1:0]       r_cnt;
    logic [AES_KEY_W-1:0]   r_key;
    logic [AES_BLOCK_W-1:0] r_cipher, r_text, w_core_text;
    logic                   w_accept;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid_i),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    Unfolded_not_pipeline_decrypt u_core (
        .clk_i    (clk_i),
        .rstn_i   (~rst_i),
        .key_i    (r_key),
        .Cipher_i (r_cipher),
        .text_o   (w_core_text)
    );

    // rst_i gate keeps ready low while reset is held with IDLE already forced
    always_comb begin
        w_accept = (r_state == IDLE) && !rst_i && (|req_valid_i);
        w_next   = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? RUN : IDLE;
            RUN:     w_next = (r_cnt == '0) ? RESP : RUN;
            RESP:    w_next = resp_ready_i ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    assign req_ready_o  = w_accept ? w_gnt : '0;
    assign resp_valid_o = (r_state == RESP);
    assign busy_o       = (r_state != IDLE);
    assign resp_id_o    = r_id;
    assign resp_text_o  = r_text;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_id     <= '0;
            r_key    <= '0;
            r_cipher <= '0;
            r_text   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_key    <= req_key_i[int'(w_gnt_idx)*AES_KEY_W +: AES_KEY_W];
                r_cipher <= req_cipher_i[int'(w_gnt_idx)*AES_BLOCK_W +: AES_BLOCK_W];
                r_id     <= w_gnt_idx;
                r_cnt    <= CNT_W'(SETTLE_CYCLES - 1);
            end
            if (r_state == RUN) begin
                if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                else             r_text <= w_core_text;
            end
            if (r_state == RESP && resp_ready_i)
                r_rr_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
        end
    end
endmodule

// File: tb/tb_aes_decrypt_scheduler.sv
// tb_aes_decrypt_scheduler: directed scenarios for the decrypt scheduler; plaintexts
// without a published answer are checked by re-encrypting them with an independent AES model.
module tb_aes_decrypt_scheduler;
    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'he01fc9945862fdd9cba66f451f0621e3;
    localparam logic [127:0] C2  = 128'hddf15219899bc752ba5a82e3e606fc72;
    localparam logic [127:0] C3A = 128'hd6bd48c2623fa09bab86d1c879cdecca;
    localparam logic [127:0] C3B = 128'hb89fe5f8c0311b2a66ef7ed62e245ef5;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   req_valid_i;
    logic [3:0]   req_ready_o;
    logic [511:0] req_key_i;
    logic [511:0] req_cipher_i;
    logic         resp_valid_o;
    logic         resp_ready_i;
    logic [1:0]   resp_id_o;
    logic [127:0] resp_text_o;
    logic         busy_o;
    int           checks = 0;
    int           failures = 0;
    logic [7:0]   sbox [256];

    always #5 clk_i = ~clk_i;

    aes_decrypt_scheduler dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_key_i    (req_key_i),
        .req_cipher_i (req_cipher_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_id_o    (resp_id_o),
        .resp_text_o  (resp_text_o),
        .busy_o       (busy_o)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // forward S-box by walking the multiplicative group with generator 3
    task automatic build_sbox;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q ^= {q[6:0], 1'b0};
            q ^= {q[5:0], 2'b0};
            q ^= {q[3:0], 4'b0};
            if (q[7]) q ^= 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rk [176];
        logic [7:0]   rc, w0, w1, w2, w3;
        logic [127:0] out;
        for (int i = 0; i < 16; i++) begin
            rk[i] = key[127-8*i -: 8];
            s[i]  = pt[127-8*i -: 8] ^ rk[i];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            {w0, w1, w2, w3} = {rk[i-4], rk[i-3], rk[i-2], rk[i-1]};
            if (i % 16 == 0) begin
                {w0, w1, w2, w3} = {sbox[w1] ^ rc, sbox[w2], sbox[w3], sbox[w0]};
                rc = xt(rc);
            end
            rk[i] = rk[i-16] ^ w0;
            rk[i+1] = rk[i-15] ^ w1;
            rk[i+2] = rk[i-14] ^ w2;
            rk[i+3] = rk[i-13] ^ w3;
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= rk[16*r+i];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int k, input logic [127:0] key, input logic [127:0] ct);
        req_key_i[128*k +: 128]    = key;
        req_cipher_i[128*k +: 128] = ct;
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (resp_valid_o) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic do_reset;
        rst_i        = 1'b1;
        req_valid_i  = '0;
        resp_ready_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i        = 1'b1;
        req_valid_i  = 4'hf;
        resp_ready_i = 1'b1;
        req_key_i    = '0;
        req_cipher_i = '0;
        tick();
        tick();
        checks++;
        if (req_ready_o !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready_o);
        end
        checks++;
        if ({resp_valid_o, resp_id_o, resp_text_o, busy_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b id=%0d text=%h busy=%b expected all zero",
                     resp_valid_o, resp_id_o, resp_text_o, busy_o);
        end
        req_valid_i = '0;
        rst_i       = 1'b0;
        tick();
    endtask

    task automatic test_single;
        set_req(0, K0, C0);
        req_valid_i = 4'b0001;
        #1;
        checks++;
        if (req_ready_o !== 4'b0001) begin
            failures++;
            $display("FAIL single_ready: got %b expected 0001", req_ready_o);
        end
        tick();
        req_valid_i = '0;
        checks++;
        if ({busy_o, req_ready_o} !== 5'b1_0000) begin
            failures++;
            $display("FAIL single_run: got busy=%b ready=%b expected busy=1 ready=0000", busy_o, req_ready_o);
        end
        tick();
        checks++;
        if (resp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL single_early: got resp_valid=%b expected 0 one cycle after accept", resp_valid_o);
        end
        tick();
        checks++;
        if (resp_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL single_latency: got resp_valid=%b expected 1 two cycles after accept", resp_valid_o);
        end
        checks++;
        if (resp_id_o !== 2'd0 || resp_text_o !== P0) begin
            failures++;
            $display("FAIL single_text: got id=%0d text=%h expected id=0 text=%h", resp_id_o, resp_text_o, P0);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        int g;
        do_reset();
        set_req(0, K0, C0);
        set_req(1, K0, C0);
        set_req(2, K2, C2);
        set_req(3, K2, C3A);
        req_valid_i = 4'hf;
        for (int n = 0; n < 5; n++) begin
            g = n % 4;
            #1;
            checks++;
            if (req_ready_o !== 4'(1 << g)) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", n, req_ready_o, 4'(1 << g));
            end
            tick();
            wait_resp(ok);
            checks++;
            if (!ok || resp_id_o !== 2'(g)) begin
                failures++;
                $display("FAIL rr_id[%0d]: got valid=%b id=%0d expected valid=1 id=%0d", n, ok, resp_id_o, g);
            end
            if (g == 0) begin
                checks++;
                if (resp_text_o !== P0) begin
                    failures++;
                    $display("FAIL rr_text0: got %h expected %h", resp_text_o, P0);
                end
            end
            if (g == 2) begin
                checks++;
                if (aes_enc(resp_text_o, K2) !== C2) begin
                    failures++;
                    $display("FAIL rr_text2: re-encrypted %h expected %h (text %h)",
                             aes_enc(resp_text_o, K2), C2, resp_text_o);
                end
            end
            tick();
        end
        req_valid_i = '0;
    endtask

    task automatic test_backpressure;
        bit ok;
        set_req(0, K0, C0);
        set_req(1, K0, C0);
        resp_ready_i = 1'b0;
        req_valid_i  = 4'b0001;
        tick();
        req_valid_i = 4'b0010;
        wait_resp(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_resp: got no response expected resp_valid within 20 cycles");
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({resp_valid_o, resp_id_o, resp_text_o, req_ready_o} !== {1'b1, 2'd0, P0, 4'b0000}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%b id=%0d text=%h ready=%b expected valid=1 id=0 text=%h ready=0000",
                         i, resp_valid_o, resp_id_o, resp_text_o, req_ready_o, P0);
            end
            tick();
        end
        resp_ready_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 4'b0000) begin
            failures++;
            $display("FAIL bp_hs_ready: got %b expected 0000 in handshake cycle", req_ready_o);
        end
        tick();
        checks++;
        if ({resp_valid_o, req_ready_o} !== 5'b0_0010) begin
            failures++;
            $display("FAIL bp_grant1: got valid=%b ready=%b expected valid=0 ready=0010", resp_valid_o, req_ready_o);
        end
        tick();
        req_valid_i = '0;
        wait_resp(ok);
        checks++;
        if (!ok || resp_id_o !== 2'd1 || resp_text_o !== P0) begin
            failures++;
            $display("FAIL bp_resp1: got valid=%b id=%0d text=%h expected valid=1 id=1 text=%h",
                     ok, resp_id_o, resp_text_o, P0);
        end
        tick();
    endtask

    task automatic test_operand_change;
        bit ok;
        set_req(3, K2, C3A);
        req_valid_i = 4'b1000;
        #1;
        checks++;
        if (req_ready_o !== 4'b1000) begin
            failures++;
            $display("FAIL oc_grant: got %b expected 1000", req_ready_o);
        end
        tick();
        set_req(3, K2, C3B);
        req_valid_i = '0;
        wait_resp(ok);
        checks++;
        if (!ok || resp_id_o !== 2'd3) begin
            failures++;
            $display("FAIL oc_id: got valid=%b id=%0d expected valid=1 id=3", ok, resp_id_o);
        end
        checks++;
        if (aes_enc(resp_text_o, K2) !== C3A) begin
            failures++;
            $display("FAIL oc_text: re-encrypted %h expected %h (text %h)", aes_enc(resp_text_o, K2), C3A, resp_text_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_run;
        bit ok;
        bit seen;
        set_req(0, K0, C0);
        set_req(2, K2, C2);
        req_valid_i = 4'b0001;
        tick();
        req_valid_i = '0;
        wait_resp(ok);
        tick();
        req_valid_i = 4'b0100;
        tick();
        rst_i = 1'b1;
        #1;
        checks++;
        if ({req_ready_o, resp_valid_o, resp_id_o, resp_text_o, busy_o} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got ready=%b valid=%b id=%0d text=%h busy=%b expected all zero",
                     req_ready_o, resp_valid_o, resp_id_o, resp_text_o, busy_o);
        end
        tick();
        req_valid_i = '0;
        rst_i       = 1'b0;
        seen        = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= resp_valid_o | busy_o;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rst_dropped: got response or busy after reset expected none");
        end
        req_valid_i = 4'hf;
        #1;
        checks++;
        if (req_ready_o !== 4'b0001) begin
            failures++;
            $display("FAIL rst_ptr0: got %b expected 0001", req_ready_o);
        end
        tick();
        req_valid_i = '0;
        wait_resp(ok);
        checks++;
        if (!ok || resp_id_o !== 2'd0 || resp_text_o !== P0) begin
            failures++;
            $display("FAIL rst_next: got valid=%b id=%0d text=%h expected valid=1 id=0 text=%h",
                     ok, resp_id_o, resp_text_o, P0);
        end
        tick();
    endtask

    task automatic test_withdrawn;
        bit ok;
        bit seen;
        req_valid_i = 4'b0001;
        tick();
        req_valid_i = 4'b0010;
        #1;
        checks++;
        if (req_ready_o !== 4'b0000) begin
            failures++;
            $display("FAIL wd_ready_run: got %b expected 0000", req_ready_o);
        end
        tick();
        req_valid_i = '0;
        wait_resp(ok);
        checks++;
        if (!ok || resp_id_o !== 2'd0) begin
            failures++;
            $display("FAIL wd_owner: got valid=%b id=%0d expected valid=1 id=0", ok, resp_id_o);
        end
        tick();
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= resp_valid_o | busy_o | (|req_ready_o);
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL wd_no_grant: got activity after withdrawn request expected none");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_operand_change();
        test_reset_mid_run();
        test_withdrawn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
